// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI bus arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } state_t;

    localparam int unsigned TMO_CYC_DEF = 4096;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Winner of an IDLE-state request; a tie goes to whoever was not served last.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return ~last;
        end
        return req0 ? REQ0 : REQ1;
    endfunction

endpackage

// File: rtl/spi_arb_if.sv
// Requester-side and SPI-master-side signals of the arbiter; slave = arbiter view.
interface spi_arb_if;

    logic        req0;
    logic        wrt0;
    logic [15:0] cmd0;
    logic        req1;
    logic        wrt1;
    logic [15:0] cmd1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [15:0] rd_data;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd_data;
    logic        tmo;

    modport slave (
        input  req0, wrt0, cmd0, req1, wrt1, cmd1, spi_done, spi_rd_data,
        output gnt0, gnt1, done0, done1, rd_data, spi_wrt, spi_cmd, tmo
    );

    modport master (
        output req0, wrt0, cmd0, req1, wrt1, cmd1, spi_done, spi_rd_data,
        input  gnt0, gnt1, done0, done1, rd_data, spi_wrt, spi_cmd, tmo
    );

endinterface

// File: rtl/spi_arb_wdog.sv
// Idle-grant watchdog: counts cycles while run is high, expires at TMO_CYC-1.
module spi_arb_wdog #(
    parameter int unsigned TMO_CYC = spi_arb_pkg::TMO_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic expire
);

    localparam int unsigned   CW    = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TMO_CYC - 1);

    logic [CW-1:0] cnt;

    // Saturates at LIMIT so a stuck clr-less run never wraps back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && (cnt != LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = run && (cnt == LIMIT);

endmodule

// File: rtl/spi_arb.sv
// Burst-locked round-robin arbiter for the shared SPI_mnrch master.
// Optional idle-grant watchdog enabled by defining SPI_ARB_TMO_EN.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    spi_arb_if.slave  bus
);

    if (TMO_CYC < 2) begin : g_tmo_chk
        $error("spi_arb: TMO_CYC must be at least 2");
    end

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        last, last_nxt;
    logic        own_req, own_wrt;
    logic [15:0] own_cmd;
    logic        expire;
    logic        spi_wrt_c, tmo_c;

    assign own_req = (owner == REQ1) ? bus.req1 : bus.req0;
    assign own_wrt = (owner == REQ1) ? bus.wrt1 : bus.wrt0;
    assign own_cmd = (owner == REQ1) ? bus.cmd1 : bus.cmd0;

`ifdef SPI_ARB_TMO_EN
    spi_arb_wdog #(
        .TMO_CYC (TMO_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state == GRANT),
        .clr    (((state == GRANT) && own_wrt) || (state_nxt != state)),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= REQ0;
            last  <= REQ1;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        spi_wrt_c = 1'b0;
        tmo_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_nxt = rr_pick(bus.req0, bus.req1, last);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // A launch strobe beats both a dropped request and an expiring watchdog.
                if (own_wrt) begin
                    spi_wrt_c = 1'b1;
                    state_nxt = XFER;
                end else if (!own_req || expire) begin
                    tmo_c     = expire;
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end
            end
            XFER: begin
                if (bus.spi_done) begin
                    state_nxt = GRANT;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.gnt0    = (state != IDLE) && (owner == REQ0);
    assign bus.gnt1    = (state != IDLE) && (owner == REQ1);
    assign bus.done0   = (state == XFER) && (owner == REQ0) && bus.spi_done;
    assign bus.done1   = (state == XFER) && (owner == REQ1) && bus.spi_done;
    assign bus.rd_data = bus.spi_rd_data;
    assign bus.spi_cmd = (state == IDLE) ? '0 : own_cmd;
    assign bus.spi_wrt = spi_wrt_c;
    assign bus.tmo     = tmo_c;

endmodule

// File: tb/tb_spi_arb.sv
// Scoreboard bench for spi_arb: directed scenarios followed by random traffic.
module tb_spi_arb;

    localparam int unsigned TMO = 16;
`ifdef SPI_ARB_TMO_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_arb_if bus();

    spi_arb #(.TMO_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          owner;
        logic [15:0] data;
    } done_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] xfer_q[$];
    done_t       done_q[$];

    // Reference model: who holds the bus (-1 = nobody), whether a transfer is in flight.
    int m_owner;
    bit m_xfer;
    int m_last;
    int m_cnt;

    logic        e_gnt0, e_gnt1, e_wrt, e_tmo, e_done0, e_done1;
    logic [15:0] e_cmd;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_xfer  = 1'b0;
        m_last  = 1;
        m_cnt   = 0;
        e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_wrt = 1'b0; e_tmo = 1'b0;
        e_done0 = 1'b0; e_done1 = 1'b0; e_cmd = 16'h0;
        xfer_q.delete();
        done_q.delete();
    endtask

    task automatic model_step();
        logic        r[2];
        logic        w[2];
        logic [15:0] c[2];
        r[0] = bus.req0; w[0] = bus.wrt0; c[0] = bus.cmd0;
        r[1] = bus.req1; w[1] = bus.wrt1; c[1] = bus.cmd1;
        e_gnt0  = (m_owner == 0);
        e_gnt1  = (m_owner == 1);
        e_wrt   = 1'b0;
        e_tmo   = 1'b0;
        e_done0 = 1'b0;
        e_done1 = 1'b0;
        e_cmd   = (m_owner < 0) ? 16'h0 : c[m_owner];
        if (m_owner < 0) begin
            if (r[0] && r[1]) m_owner = 1 - m_last;
            else if (r[0])    m_owner = 0;
            else if (r[1])    m_owner = 1;
            m_cnt  = 0;
            m_xfer = 1'b0;
        end else if (m_xfer) begin
            if (bus.spi_done) begin
                if (m_owner == 0) e_done0 = 1'b1;
                else              e_done1 = 1'b1;
                done_q.push_back('{m_owner, bus.spi_rd_data});
                m_xfer = 1'b0;
                m_cnt  = 0;
            end
        end else if (w[m_owner]) begin
            e_wrt = 1'b1;
            xfer_q.push_back(c[m_owner]);
            m_xfer = 1'b1;
        end else begin
            bit expired;
            expired = TMO_ON && (m_cnt == int'(TMO) - 1);
            e_tmo   = expired;
            if (!r[m_owner] || expired) begin
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [15:0] c0,
                         input logic r1, input logic w1, input logic [15:0] c1,
                         input logic sd, input logic [15:0] rd);
        @(posedge clk);
        #1;
        bus.req0 = r0; bus.wrt0 = w0; bus.cmd0 = c0;
        bus.req1 = r1; bus.wrt1 = w1; bus.cmd1 = c1;
        bus.spi_done = sd; bus.spi_rd_data = rd;
        model_step();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("gnt0", bus.gnt0, e_gnt0);
            chk("gnt1", bus.gnt1, e_gnt1);
            chk("tmo", bus.tmo, e_tmo);
            chk("spi_wrt", bus.spi_wrt, e_wrt);
            chk("spi_cmd", bus.spi_cmd, e_cmd);
            chk("done0", bus.done0, e_done0);
            chk("done1", bus.done1, e_done1);
            if (bus.spi_wrt) begin
                if (xfer_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_wrt: got spi_wrt=1 expected no launch at %0t", $time);
                end else begin
                    chk("wrt_cmd", bus.spi_cmd, xfer_q.pop_front());
                end
            end
            if (bus.done0 || bus.done1) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_done: got done0=%b done1=%b expected none at %0t",
                             bus.done0, bus.done1, $time);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_owner", {15'h0, bus.done1}, 16'(d.owner));
                    chk("done_rd_data", bus.rd_data, d.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish within 2ms");
        $fatal(1);
    end

    initial begin
        bus.req0 = 1'b0; bus.wrt0 = 1'b0; bus.cmd0 = 16'h0;
        bus.req1 = 1'b0; bus.wrt1 = 1'b0; bus.cmd1 = 16'h0;
        bus.spi_done = 1'b0; bus.spi_rd_data = 16'h0;
        model_reset();
        #12;
        chk("rst_gnt0", bus.gnt0, 16'h0);
        chk("rst_gnt1", bus.gnt1, 16'h0);
        chk("rst_spi_wrt", bus.spi_wrt, 16'h0);
        chk("rst_tmo", bus.tmo, 16'h0);
        #10;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single requester 0 transaction, done 16 clocks after the launch.
        drive(1, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
        drive(1, 1, 16'hA200, 0, 0, 16'h0, 0, 16'h0);
        for (int i = 0; i < 15; i++) drive(1, 0, 16'hA200, 0, 0, 16'h0, 0, 16'h0);
        drive(1, 0, 16'hA200, 0, 0, 16'h0, 1, 16'h0034);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);

        // Simultaneous requests: round-robin hand-over and repeat.
        for (int i = 0; i < 3; i++) drive(1, 0, 16'h0, 1, 0, 16'h7777, 0, 16'h0);
        for (int i = 0; i < 4; i++) drive(0, 0, 16'h0, 1, 0, 16'h7777, 0, 16'h0);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
        for (int i = 0; i < 3; i++) drive(1, 0, 16'h1111, 1, 0, 16'h2222, 0, 16'h0);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);

        // Requester 1 owns: a non-owner strobe must be dropped in GRANT and XFER.
        drive(0, 0, 16'h0, 1, 0, 16'h5A5A, 0, 16'h0);
        drive(0, 1, 16'h1053, 1, 0, 16'h5A5A, 0, 16'h0);
        drive(0, 0, 16'h1053, 1, 1, 16'h5A5A, 0, 16'h0);
        drive(0, 1, 16'h1053, 1, 0, 16'h5A5A, 0, 16'h0);
        drive(0, 0, 16'h1053, 1, 0, 16'h5A5A, 1, 16'hBEEF);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 1, 16'h0);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);

        // Owner drops req mid-XFER: done still delivered, then release.
        drive(1, 0, 16'h0BEE, 0, 0, 16'h0, 0, 16'h0);
        drive(1, 1, 16'h0BEE, 0, 0, 16'h0, 0, 16'h0);
        drive(0, 0, 16'h0BEE, 0, 0, 16'h0, 0, 16'h0);
        drive(0, 0, 16'h0BEE, 0, 0, 16'h0, 1, 16'h1234);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);

        // Hung requester 1: revoked by the watchdog if enabled, otherwise held.
        for (int i = 0; i < (TMO_ON ? 26 : 1000); i++)
            drive(logic'(i >= 3), 0, 16'hC0DE, 1, 0, 16'hDEAD, 0, 16'h0);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);

        // Reset in the middle of a transfer.
        drive(0, 0, 16'h0, 1, 0, 16'h3C00, 0, 16'h0);
        drive(0, 0, 16'h0, 1, 1, 16'h3C00, 0, 16'h0);
        drive(0, 0, 16'h0, 1, 0, 16'h3C00, 0, 16'h0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("arst_gnt0", bus.gnt0, 16'h0);
        chk("arst_gnt1", bus.gnt1, 16'h0);
        chk("arst_spi_wrt", bus.spi_wrt, 16'h0);
        chk("arst_tmo", bus.tmo, 16'h0);
        model_reset();
        bus.req0 = 1'b0; bus.wrt0 = 1'b0; bus.req1 = 1'b0; bus.wrt1 = 1'b0;
        bus.spi_done = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) drive(1, 0, 16'h4444, 1, 0, 16'h8888, 0, 16'h0);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);

        // Random traffic.
        begin
            logic r0, r1;
            r0 = 1'b0;
            r1 = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(7) == 0) r0 = ~r0;
                if ($urandom_range(7) == 0) r1 = ~r1;
                drive(r0, logic'($urandom_range(2) == 0), 16'($urandom),
                      r1, logic'($urandom_range(2) == 0), 16'($urandom),
                      logic'($urandom_range(3) == 0), 16'($urandom));
            end
        end
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
        @(negedge clk);
        #1;
        chk("xfer_q_empty", 16'(xfer_q.size()), 16'h0);
        chk("done_q_empty", 16'(done_q.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
